mux_2_to_1: RTL and testbench

MUX_2_TO_1 -- requirements
Module: mux_2_to_1

---
 rtl/mux_2_to_1_if.sv | 15 +
 rtl/mux_2_to_1.sv | 39 +++
 tb/tb_mux_2_to_1.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mux_2_to_1_if.sv
// Signal bundle for one mux_2_to_1 cell: data/select in, combinational and
// registered results out. The cell itself keeps plain ports for positional use.
interface mux_2_to_1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             s;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic             s_q;

  modport master (output x, output y, output s, input m, input q, input s_q);
  modport slave  (input x, input y, input s, output m, output q, output s_q);
endinterface

// File: rtl/mux_2_to_1.sv
// 2:1 mux cell with a combinational output plus a registered copy of the
// result and of the select, for building cascaded mux trees.
module mux_2_to_1 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             S,
  output logic [WIDTH-1:0] M,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] Q,
  output logic             S_q
);

  logic [WIDTH-1:0] w_m;
  logic [WIDTH-1:0] r_q;
  logic             r_s_q;

  // Conditional operator merges bitwise on an unknown select, so bits where
  // X and Y agree stay known and differing bits go X.
  assign w_m = S ? Y : X;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= RESET_VAL;
      r_s_q <= 1'b0;
    end else begin
      r_q   <= w_m;
      r_s_q <= S;
    end
  end

  assign M   = w_m;
  assign Q   = r_q;
  assign S_q = r_s_q;

endmodule

// File: tb/tb_mux_2_to_1.sv
// Directed bench: 8-bit cell with a scoreboard for registered outputs,
// exhaustive 1-bit truth table, and a seven-cell 8:1 tree.
module tb_mux_2_to_1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [8:0] sb_q [$];

  mux_2_to_1_if #(.WIDTH(8)) bus ();

  mux_2_to_1 #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .X(bus.x), .Y(bus.y), .S(bus.s), .M(bus.m),
    .clk(clk), .rst_n(rst_n), .Q(bus.q), .S_q(bus.s_q)
  );

  // Single-bit cell for the truth table.
  logic x1, y1, s1, m1, q1, sq1;
  mux_2_to_1 cell1 (
    .X(x1), .Y(y1), .S(s1), .M(m1),
    .clk(clk), .rst_n(rst_n), .Q(q1), .S_q(sq1)
  );

  // 8:1 tree, LSB select level first.
  logic [7:0] t_in;
  logic [2:0] t_sel;
  logic [3:0] lvl0;
  logic [1:0] lvl1;
  logic       t_out;
  logic [6:0] t_q;
  logic [6:0] t_sq;

  for (genvar g = 0; g < 4; g++) begin : g_l0
    mux_2_to_1 c (
      .X(t_in[2*g]), .Y(t_in[2*g+1]), .S(t_sel[0]), .M(lvl0[g]),
      .clk(clk), .rst_n(rst_n), .Q(t_q[g]), .S_q(t_sq[g])
    );
  end
  for (genvar g = 0; g < 2; g++) begin : g_l1
    mux_2_to_1 c (
      .X(lvl0[2*g]), .Y(lvl0[2*g+1]), .S(t_sel[1]), .M(lvl1[g]),
      .clk(clk), .rst_n(rst_n), .Q(t_q[4+g]), .S_q(t_sq[4+g])
    );
  end
  mux_2_to_1 c_top (
    .X(lvl1[0]), .Y(lvl1[1]), .S(t_sel[2]), .M(t_out),
    .clk(clk), .rst_n(rst_n), .Q(t_q[6]), .S_q(t_sq[6])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, check M, queue the expected capture,
  // then check Q/S_q just after the rising edge.
  task automatic step(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [7:0] exp_m;
    logic [8:0] e;
    @(negedge clk);
    bus.x = x;
    bus.y = y;
    bus.s = s;
    exp_m = s ? y : x;
    #1;
    chk("comb_m", {24'd0, bus.m}, {24'd0, exp_m});
    sb_q.push_back({exp_m, s});
    @(posedge clk);
    #1;
    chk("sb_not_empty", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("reg_q", {24'd0, bus.q}, {24'd0, e[8:1]});
      chk("reg_s_q", {31'd0, bus.s_q}, {31'd0, e[0]});
    end
  endtask

  initial begin
    logic [7:0] tt_exp;
    total = 0;
    bad   = 0;
    tt_exp = 8'b1101_1000;
    bus.x = 8'h00; bus.y = 8'h00; bus.s = 1'b0;
    x1 = 1'b0; y1 = 1'b0; s1 = 1'b0;
    t_in = 8'h00; t_sel = 3'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_q", {24'd0, bus.q}, 32'h00);
    chk("rst_s_q", {31'd0, bus.s_q}, 32'd0);

    // Clock edges during reset leave state alone; M still follows inputs.
    bus.x = 8'h5A; bus.s = 1'b1; bus.y = 8'hC3;
    @(posedge clk); #1;
    chk("rst_hold_q", {24'd0, bus.q}, 32'h00);
    chk("rst_hold_s_q", {31'd0, bus.s_q}, 32'd0);
    chk("rst_m_live", {24'd0, bus.m}, 32'hC3);

    @(negedge clk) rst_n = 1'b1;

    step(8'hA5, 8'h3C, 1'b0);
    step(8'hA5, 8'h3C, 1'b1);
    step(8'h0F, 8'hF0, 1'b0);
    step(8'hFF, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++)
      step(8'($urandom), 8'($urandom), 1'($urandom));
    step(8'hA5, 8'h3C, 1'b1);

    // Async reset between edges, Q currently 3C.
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", {24'd0, bus.q}, 32'h00);
    chk("async_s_q", {31'd0, bus.s_q}, 32'd0);
    chk("async_m", {24'd0, bus.m}, 32'h3C);
    @(negedge clk);
    bus.x = 8'h00; bus.y = 8'hFF; bus.s = 1'b1;
    @(posedge clk); #1;
    chk("discard_q", {24'd0, bus.q}, 32'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_q", {24'd0, bus.q}, 32'hFF);
    chk("release_s_q", {31'd0, bus.s_q}, 32'd1);

    // Exhaustive 1-bit truth table, {X,Y,S} with S as LSB.
    for (int i = 0; i < 8; i++) begin
      x1 = i[2]; y1 = i[1]; s1 = i[0];
      #10;
      chk("tt_m", {31'd0, m1}, {31'd0, tt_exp[i]});
    end

    // 8:1 tree: one-hot inputs against every select code.
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 8; s++) begin
        t_in  = 8'h01 << k;
        t_sel = 3'(s);
        #1;
        chk("tree_out", {31'd0, t_out}, (k == s) ? 32'd1 : 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
